// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, encodings and helpers for the keypad calculator
package calc_pkg;

    localparam logic [1:0] OPD_DIGITS = 2'd2;
    localparam int         RES_W      = 14;
    localparam logic [3:0] CONV_CYC   = 4'd14;

    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_ENT  = 4'd13;
    localparam logic [3:0] KEY_NONE = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_CALC = 3'd2,
        S_CONV = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    function automatic logic [RES_W-1:0] bcd2bin(input logic [3:0] t, input logic [3:0] o);
        return RES_W'(t) * RES_W'(10) + RES_W'(o);
    endfunction

    function automatic op_t key2op(input logic [3:0] key);
        case (key)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// rtl/calc_ctrl_if.sv - key input and display/status bundle of the calculator controller
interface calc_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_in;
    logic [15:0] disp_bcd;
    logic        neg;
    logic [1:0]  op;
    logic        busy;
    logic        result_valid;
    logic [2:0]  state;

    modport master (
        output key_valid, key_in,
        input  disp_bcd, neg, op, busy, result_valid, state
    );

    modport slave (
        input  key_valid, key_in,
        output disp_bcd, neg, op, busy, result_valid, state
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 4-digit BCD converter
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RES_W-1:0] bin,
    output logic [15:0]      bcd,
    output logic             done
);

    logic [RES_W-1:0] sh;
    logic [15:0]      acc;
    logic [15:0]      acc_adj;
    logic [3:0]       cnt;
    logic [RES_W+15:0] shifted;

    // Add-3 to every digit that would overflow past 9 once doubled.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
        shifted = {acc_adj, sh} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            acc  <= '0;
            cnt  <= CONV_CYC;
            done <= 1'b0;
        end else if (cnt != 4'd0) begin
            acc  <= shifted[RES_W+15:RES_W];
            sh   <= shifted[RES_W-1:0];
            cnt  <= cnt - 4'd1;
            done <= (cnt == 4'd1);
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - key sequencing, arithmetic and display control of the keypad calculator
module calc_ctrl
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    calc_ctrl_if.slave  bus
);

    state_t      state_q, state_n;
    logic [3:0]  a_t_q, a_t_n, a_o_q, a_o_n;
    logic [3:0]  b_t_q, b_t_n, b_o_q, b_o_n;
    logic [1:0]  a_cnt_q, a_cnt_n, b_cnt_q, b_cnt_n;
    op_t         op_q, op_n;
    logic        neg_q, neg_n;
    logic [15:0] res_bcd_q, res_bcd_n;
    logic        rv_q, rv_n;

    logic             busy;
    logic             key_ok, is_digit, is_op, is_ent;
    logic             clr, load_first;
    logic             start;
    logic [RES_W-1:0] a_bin, b_bin, res_bin;
    logic [15:0]      conv_bcd;
    logic             conv_done;

    assign busy     = (state_q == S_CALC) || (state_q == S_CONV);
    assign key_ok   = bus.key_valid && !busy;
    assign is_digit = (bus.key_in <= 4'd9);
    assign is_op    = (bus.key_in == KEY_ADD) || (bus.key_in == KEY_SUB) || (bus.key_in == KEY_MUL);
    assign is_ent   = (bus.key_in == KEY_ENT);
    assign a_bin    = bcd2bin(a_t_q, a_o_q);
    assign b_bin    = bcd2bin(b_t_q, b_o_q);

    always_comb begin
        state_n    = state_q;
        a_t_n      = a_t_q;
        a_o_n      = a_o_q;
        a_cnt_n    = a_cnt_q;
        b_t_n      = b_t_q;
        b_o_n      = b_o_q;
        b_cnt_n    = b_cnt_q;
        op_n       = op_q;
        neg_n      = neg_q;
        res_bcd_n  = res_bcd_q;
        rv_n       = 1'b0;
        start      = 1'b0;
        res_bin    = '0;
        clr        = 1'b0;
        load_first = 1'b0;

        case (state_q)
            S_A: begin
                if (key_ok && is_digit && (a_cnt_q < OPD_DIGITS)) begin
                    a_t_n   = a_o_q;
                    a_o_n   = bus.key_in;
                    a_cnt_n = a_cnt_q + 2'd1;
                end else if (key_ok && is_op) begin
                    op_n    = key2op(bus.key_in);
                    state_n = S_B;
                end
            end
            S_B: begin
                if (key_ok && is_digit && (b_cnt_q < OPD_DIGITS)) begin
                    b_t_n   = b_o_q;
                    b_o_n   = bus.key_in;
                    b_cnt_n = b_cnt_q + 2'd1;
                end else if (key_ok && is_op && (b_cnt_q == 2'd0)) begin
                    op_n = key2op(bus.key_in);
                end else if (key_ok && is_ent) begin
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                start = 1'b1;
                case (op_q)
                    OP_MUL: res_bin = a_bin * b_bin;
                    OP_SUB: begin
                        if (a_bin >= b_bin) begin
                            res_bin = a_bin - b_bin;
                            neg_n   = 1'b0;
                        end else begin
                            res_bin = b_bin - a_bin;
                            neg_n   = 1'b1;
                        end
                    end
                    default: res_bin = a_bin + b_bin;
                endcase
                state_n = S_CONV;
            end
            S_CONV: begin
                if (conv_done) begin
                    res_bcd_n = conv_bcd;
                    rv_n      = 1'b1;
                    state_n   = S_SHOW;
                end
            end
            S_SHOW: begin
                if (key_ok && is_digit) begin
                    clr        = 1'b1;
                    load_first = 1'b1;
                end else if (key_ok && is_ent) begin
                    clr = 1'b1;
                end
            end
            default: clr = 1'b1;
        endcase

        // A fresh calculation starts from a fully cleared context.
        if (clr) begin
            state_n   = S_A;
            a_t_n     = '0;
            a_o_n     = '0;
            a_cnt_n   = '0;
            b_t_n     = '0;
            b_o_n     = '0;
            b_cnt_n   = '0;
            op_n      = OP_ADD;
            neg_n     = 1'b0;
            res_bcd_n = '0;
            rv_n      = 1'b0;
        end
        if (load_first) begin
            a_o_n   = bus.key_in;
            a_cnt_n = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_A;
            a_t_q     <= '0;
            a_o_q     <= '0;
            a_cnt_q   <= '0;
            b_t_q     <= '0;
            b_o_q     <= '0;
            b_cnt_q   <= '0;
            op_q      <= OP_ADD;
            neg_q     <= 1'b0;
            res_bcd_q <= '0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_n;
            a_t_q     <= a_t_n;
            a_o_q     <= a_o_n;
            a_cnt_q   <= a_cnt_n;
            b_t_q     <= b_t_n;
            b_o_q     <= b_o_n;
            b_cnt_q   <= b_cnt_n;
            op_q      <= op_n;
            neg_q     <= neg_n;
            res_bcd_q <= res_bcd_n;
            rv_q      <= rv_n;
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (res_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        case (state_q)
            S_A:     bus.disp_bcd = {8'h00, a_t_q, a_o_q};
            S_B:     bus.disp_bcd = {8'h00, b_t_q, b_o_q};
            default: bus.disp_bcd = res_bcd_q;
        endcase
    end

    assign bus.neg          = neg_q;
    assign bus.op           = op_q;
    assign bus.busy         = busy;
    assign bus.result_valid = rv_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - directed self-checking bench for calc_ctrl
module tb_calc_ctrl;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    calc_ctrl_if bus ();

    calc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the key is sampled on the following rising edge.
    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_in    = KEY_NONE;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_result(input int start_n, input logic [15:0] exp_bcd,
                               input logic exp_neg, input string tag);
        int n;
        n = start_n;
        while (!bus.result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 16);
        check({tag, "_disp"}, bus.disp_bcd, exp_bcd);
        check({tag, "_neg"}, bus.neg, exp_neg);
        check({tag, "_state"}, bus.state, S_SHOW);
        @(negedge clk);
        check({tag, "_rv_once"}, bus.result_valid, 1'b0);
    endtask

    initial begin
        int rv_seen;
        bus.key_valid = 1'b0;
        bus.key_in    = KEY_NONE;
        @(negedge clk);
        do_reset();
        check("rst_disp", bus.disp_bcd, 16'h0000);
        check("rst_neg", bus.neg, 1'b0);
        check("rst_state", bus.state, S_A);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rv", bus.result_valid, 1'b0);
        check("rst_op", bus.op, OP_ADD);

        press(4'd1); press(4'd2);
        check("add_a_disp", bus.disp_bcd, 16'h0012);
        press(KEY_NONE);
        check("none_ignored", bus.disp_bcd, 16'h0012);
        press(KEY_ENT);
        check("ent_in_a", bus.state, S_A);
        press(KEY_ADD);
        check("add_state_b", bus.state, S_B);
        check("add_b_empty", bus.disp_bcd, 16'h0000);
        press(4'd3); press(4'd4);
        check("add_b_disp", bus.disp_bcd, 16'h0034);
        press(KEY_ENT);
        check("add_calc", bus.state, S_CALC);
        check("add_busy", bus.busy, 1'b1);
        wait_result(0, 16'h0046, 1'b0, "add");

        press(4'd5);
        check("sub_a_disp", bus.disp_bcd, 16'h0005);
        check("sub_a_state", bus.state, S_A);
        press(KEY_SUB); press(4'd1); press(4'd2);
        check("sub_op", bus.op, OP_SUB);
        press(KEY_ENT);
        wait_result(0, 16'h0007, 1'b1, "sub");
        press(4'd3);
        check("show_digit_state", bus.state, S_A);
        check("show_digit_disp", bus.disp_bcd, 16'h0003);
        check("show_digit_neg", bus.neg, 1'b0);
        check("show_digit_op", bus.op, OP_ADD);

        do_reset();
        press(4'd9); press(4'd9); press(KEY_MUL); press(4'd9); press(4'd9);
        press(KEY_ENT);
        wait_result(0, 16'h9801, 1'b0, "mul");

        press(KEY_ENT);
        check("show_ent_state", bus.state, S_A);
        check("show_ent_disp", bus.disp_bcd, 16'h0000);
        press(4'd1); press(4'd2); press(4'd3);
        check("third_digit", bus.disp_bcd, 16'h0012);
        press(KEY_ADD); press(KEY_MUL);
        check("op_replace", bus.op, OP_MUL);
        press(4'd2);
        press(KEY_SUB);
        check("op_locked", bus.op, OP_MUL);
        check("b_one_digit", bus.disp_bcd, 16'h0002);
        press(KEY_ENT);
        wait_result(0, 16'h0024, 1'b0, "bnd");

        press(4'd1); press(KEY_ADD); press(4'd1); press(KEY_ENT);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("conv_busy", bus.busy, 1'b1);
        check("conv_state", bus.state, S_CONV);
        press(4'd7);
        wait_result(4, 16'h0002, 1'b0, "busy");
        press(KEY_ADD);
        check("show_op_state", bus.state, S_SHOW);
        check("show_op_disp", bus.disp_bcd, 16'h0002);

        press(KEY_ENT);
        press(4'd3); press(KEY_ADD); press(4'd4); press(KEY_ENT);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("pre_rst_conv", bus.state, S_CONV);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", bus.state, S_A);
        check("mid_rst_disp", bus.disp_bcd, 16'h0000);
        check("mid_rst_busy", bus.busy, 1'b0);
        rv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.result_valid) rv_seen++;
        end
        check("mid_rst_no_rv", rv_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
